match_controller: RTL

//  Sequences a ping-pong match around the lamp_handball datapath: start, serve, rally, point pause, match over.

---
 rtl/match_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/match_controller.sv
// Match sequencer for the lamp_handball game: owns scores, serve rotation and win
// detection, and gates ball movement (rally_en) around serve, rally and point pauses.
module match_controller #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_TICKS  = 10,
  parameter int SERVE_SWITCH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       abort,
  input  logic       hit_p1,
  input  logic       hit_p2,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       server,
  output logic       serve_req,
  output logic       rally_en,
  output logic       level_lock,
  output logic       match_over,
  output logic       winner,
  output logic       blink
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam int PW = $clog2(PAUSE_TICKS + 1);
  localparam int RW = $clog2(SERVE_SWITCH + 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
  localparam logic [RW-1:0] ROT_LAST   = RW'(SERVE_SWITCH - 1);

  typedef enum logic [2:0] {
    IDLE, SERVE_WAIT, RALLY, POINT_PAUSE, MATCH_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    score_p1_q, score_p2_q;
  logic [PW-1:0] pause_q;
  logic [RW-1:0] rot_q, rot_next;
  logic          server_q, winner_q, blink_q;
  logic          serve_req_q, rally_en_q, level_lock_q, match_over_q;

  logic p1_scores, p2_scores, p1_wins, p2_wins, serve_hit, pause_done;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    p1_scores  = (state_q == RALLY) && point_p1 && !point_p2;
    p2_scores  = (state_q == RALLY) && point_p2 && !point_p1;
    p1_wins    = p1_scores && (score_p1_q + 4'd1 == WIN);
    p2_wins    = p2_scores && (score_p2_q + 4'd1 == WIN);
    serve_hit  = server_q ? hit_p2 : hit_p1;
    pause_done = tick && (pause_q == PAUSE_LAST);
    rot_next   = (rot_q == ROT_LAST) ? '0 : rot_q + RW'(1);

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:        if (start) state_d = SERVE_WAIT;
        SERVE_WAIT:  if (serve_hit) state_d = RALLY;
        RALLY: begin
          if (point_p1 && point_p2)       state_d = SERVE_WAIT;
          else if (p1_wins || p2_wins)    state_d = MATCH_OVER;
          else if (p1_scores || p2_scores) state_d = POINT_PAUSE;
        end
        POINT_PAUSE: if (pause_done) state_d = SERVE_WAIT;
        MATCH_OVER:  if (start) state_d = SERVE_WAIT;
        default:     state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      pause_q      <= '0;
      rot_q        <= '0;
      server_q     <= 1'b0;
      winner_q     <= 1'b0;
      blink_q      <= 1'b0;
      serve_req_q  <= 1'b0;
      rally_en_q   <= 1'b0;
      level_lock_q <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      serve_req_q  <= (state_d == SERVE_WAIT);
      rally_en_q   <= (state_d == RALLY);
      level_lock_q <= (state_d != IDLE) && (state_d != MATCH_OVER);
      match_over_q <= (state_d == MATCH_OVER);

      if (abort) begin
        score_p1_q <= '0;
        score_p2_q <= '0;
        pause_q    <= '0;
        rot_q      <= '0;
        server_q   <= 1'b0;
        winner_q   <= 1'b0;
        blink_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            score_p1_q <= '0;
            score_p2_q <= '0;
            if (start) begin
              server_q <= 1'b0;
              rot_q    <= '0;
            end
          end
          RALLY: begin
            // Entering the pause (or the end of the match) always restarts the tick count.
            if (p1_scores || p2_scores) begin
              rot_q   <= rot_next;
              pause_q <= '0;
            end
            if (p1_scores && score_p1_q < WIN) score_p1_q <= score_p1_q + 4'd1;
            if (p2_scores && score_p2_q < WIN) score_p2_q <= score_p2_q + 4'd1;
            if (p1_wins) winner_q <= 1'b0;
            if (p2_wins) winner_q <= 1'b1;
          end
          POINT_PAUSE: begin
            if (pause_done) begin
              pause_q <= '0;
              if (rot_q == '0) server_q <= ~server_q;
            end else if (tick) begin
              pause_q <= pause_q + PW'(1);
            end
          end
          MATCH_OVER: begin
            if (start) begin
              score_p1_q <= '0;
              score_p2_q <= '0;
              pause_q    <= '0;
              rot_q      <= '0;
              server_q   <= 1'b0;
              winner_q   <= 1'b0;
              blink_q    <= 1'b0;
            end else if (tick) begin
              blink_q <= ~blink_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign server     = server_q;
  assign serve_req  = serve_req_q;
  assign rally_en   = rally_en_q;
  assign level_lock = level_lock_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;
  assign blink      = blink_q;

endmodule
